keypad_entry_ctrl: RTL and testbench

KEYPAD_ENTRY_CTRL -- requirements
Module: keypad_entry_ctrl

---
 rtl/keypad_entry_ctrl.sv | 158 +++++++++++++++
 tb/tb_keypad_entry_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry_ctrl.sv
// PS/2 set-2 keypad entry controller: collects BCD digits, commits on Enter, holds until acked.
// Optional backspace key (0x66) is enabled by defining KEYPAD_BACKSPACE_EN.
module keypad_entry_ctrl #(
  parameter int unsigned MAX_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              code_in,
  input  logic                    code_valid,
  output logic                    code_ready,
  output logic [4*MAX_DIGITS-1:0] digits_out,
  output logic [3:0]              digit_count,
  output logic                    result_valid,
  input  logic                    result_ack,
  output logic                    entry_err
);

  localparam int unsigned DW = 4 * MAX_DIGITS;

  localparam logic [1:0] StCollect = 2'd0;
  localparam logic [1:0] StPrefix  = 2'd1;
  localparam logic [1:0] StBreak   = 2'd2;
  localparam logic [1:0] StHold    = 2'd3;

  localparam logic [3:0] MaxCount = 4'(MAX_DIGITS);

  localparam logic [7:0] KeyEnter = 8'h5A;
  localparam logic [7:0] KeyEsc   = 8'h76;
  localparam logic [7:0] KeyBreak = 8'hF0;
  localparam logic [7:0] KeyExt   = 8'hE0;
`ifdef KEYPAD_BACKSPACE_EN
  localparam logic [7:0] KeyBksp  = 8'h66;
`endif

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] digits_q, digits_d;
  logic [3:0]    count_q, count_d;
  logic          err_q, err_d;
  logic          result_valid_q;

  logic          accept;
  logic          dec_valid;
  logic [3:0]    dec_digit;
  logic [DW-1:0] dig_ext;

  // scan_to_digit: set-2 make codes of the main-row digit keys
  always_comb begin
    dec_valid = 1'b1;
    dec_digit = 4'd0;
    case (code_in)
      8'h45:   dec_digit = 4'd0;
      8'h16:   dec_digit = 4'd1;
      8'h1E:   dec_digit = 4'd2;
      8'h26:   dec_digit = 4'd3;
      8'h25:   dec_digit = 4'd4;
      8'h2E:   dec_digit = 4'd5;
      8'h36:   dec_digit = 4'd6;
      8'h3D:   dec_digit = 4'd7;
      8'h3E:   dec_digit = 4'd8;
      8'h46:   dec_digit = 4'd9;
      default: dec_valid = 1'b0;
    endcase
  end

  assign code_ready = (state_q != StHold);
  assign accept     = code_valid & code_ready;

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    count_d  = count_q;
    err_d    = 1'b0;
    dig_ext  = '0;
    dig_ext[3:0] = dec_digit;

    unique case (state_q)
      StCollect: begin
        if (accept) begin
          if (dec_valid) begin
            if (count_q < MaxCount) begin
              digits_d = (digits_q << 4) | dig_ext;
              count_d  = count_q + 4'd1;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            case (code_in)
              KeyEnter: begin
                if (count_q != 4'd0) state_d = StHold;
                else                 err_d   = 1'b1;
              end
              KeyEsc: begin
                digits_d = '0;
                count_d  = 4'd0;
              end
              KeyBreak: state_d = StBreak;
              KeyExt:   state_d = StPrefix;
`ifdef KEYPAD_BACKSPACE_EN
              KeyBksp: begin
                if (count_q != 4'd0) begin
                  digits_d = digits_q >> 4;
                  count_d  = count_q - 4'd1;
                end
              end
`endif
              default: ;
            endcase
          end
        end
      end
      StPrefix: begin
        if (accept) begin
          state_d = StCollect;
          if (code_in == KeyBreak) begin
            state_d = StBreak;
          end else if (code_in == KeyEnter) begin
            // Keypad Enter (E0 5A) commits like the main Enter key
            if (count_q != 4'd0) state_d = StHold;
            else                 err_d   = 1'b1;
          end
        end
      end
      StBreak: begin
        if (accept) state_d = StCollect;
      end
      StHold: begin
        if (result_ack) begin
          digits_d = '0;
          count_d  = 4'd0;
          state_d  = StCollect;
        end
      end
      default: state_d = StCollect;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StCollect;
      digits_q       <= '0;
      count_q        <= 4'd0;
      err_q          <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      digits_q       <= digits_d;
      count_q        <= count_d;
      err_q          <= err_d;
      result_valid_q <= (state_d == StHold);
    end
  end

  assign digits_out   = digits_q;
  assign digit_count  = count_q;
  assign entry_err    = err_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl: directed vector table, hand-written reset/backspace sequences,
// and randomized bytes checked against a queue-based behavioural model.
module tb_keypad_entry_ctrl;

  localparam int unsigned MAXD = 4;

  localparam logic [7:0] SCAN [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                       8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       code_in = 8'h00;
  logic             code_valid = 1'b0;
  logic             code_ready;
  logic [4*MAXD-1:0] digits_out;
  logic [3:0]       digit_count;
  logic             result_valid;
  logic             result_ack = 1'b0;
  logic             entry_err;

  int vectors = 0;
  int miscompares = 0;

  keypad_entry_ctrl #(.MAX_DIGITS(MAXD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .code_in      (code_in),
    .code_valid   (code_valid),
    .code_ready   (code_ready),
    .digits_out   (digits_out),
    .digit_count  (digit_count),
    .result_valid (result_valid),
    .result_ack   (result_ack),
    .entry_err    (entry_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  code;
    bit          valid;
    bit          ack;
    logic [15:0] digits;
    logic [3:0]  count;
    bit          rv;
    bit          err;
    bit          rdy;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model: entered digits kept as a queue, oldest first
  int m_q[$];
  bit m_brk, m_pre, m_hold, m_err;

  task automatic add(input logic [7:0] c, input bit v, input bit a, input logic [15:0] d,
                     input logic [3:0] n, input bit rv, input bit err, input bit rdy);
    vec_t e;
    e.code = c; e.valid = v; e.ack = a; e.digits = d; e.count = n;
    e.rv = rv; e.err = err; e.rdy = rdy;
    tbl.push_back(e);
  endtask

  task automatic check(input string name, input logic [15:0] ed, input logic [3:0] ec,
                       input bit erv, input bit eerr, input bit erdy);
    vectors++;
    if (digits_out !== ed || digit_count !== ec || result_valid !== erv ||
        entry_err !== eerr || code_ready !== erdy) begin
      miscompares++;
      $display("FAIL %s: got digits=%h count=%0d rv=%b err=%b rdy=%b, want digits=%h count=%0d rv=%b err=%b rdy=%b",
               name, digits_out, digit_count, result_valid, entry_err, code_ready,
               ed, ec, erv, eerr, erdy);
    end
  endtask

  task automatic drive(input logic [7:0] c, input bit v, input bit a);
    @(negedge clk);
    code_in = c; code_valid = v; result_ack = a;
    @(posedge clk);
    #1;
  endtask

  function automatic int digit_of(input logic [7:0] c);
    for (int i = 0; i < 10; i++) if (SCAN[i] == c) return i;
    return -1;
  endfunction

  function automatic logic [15:0] m_value();
    int v = 0;
    foreach (m_q[i]) v = v * 16 + m_q[i];
    return 16'(v);
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_brk = 0; m_pre = 0; m_hold = 0; m_err = 0;
  endtask

  task automatic m_enter();
    if (m_q.size() > 0) m_hold = 1;
    else                m_err  = 1;
  endtask

  task automatic model_step(input logic [7:0] c, input bit v, input bit a);
    int d;
    m_err = 0;
    if (m_hold) begin
      if (a) begin
        m_q.delete();
        m_hold = 0;
      end
    end else if (v) begin
      if (m_brk) begin
        m_brk = 0;
      end else if (m_pre) begin
        m_pre = 0;
        if (c == 8'hF0)      m_brk = 1;
        else if (c == 8'h5A) m_enter();
      end else begin
        d = digit_of(c);
        if (d >= 0) begin
          if (m_q.size() < MAXD) m_q.push_back(d);
          else                   m_err = 1;
        end else if (c == 8'h5A) m_enter();
        else if (c == 8'h76) m_q.delete();
        else if (c == 8'hF0) m_brk = 1;
        else if (c == 8'hE0) m_pre = 1;
`ifdef KEYPAD_BACKSPACE_EN
        else if (c == 8'h66 && m_q.size() > 0) void'(m_q.pop_back());
`endif
      end
    end
  endtask

  initial begin
    logic [7:0] c;
    bit v, a;
    int r;

    // Reset state, before and across clock edges
    #3;
    check("reset_async", 16'h0, 4'd0, 0, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", 16'h0, 4'd0, 0, 0, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Commit 123, hold ignores bytes, ack clears
    add(8'h16, 1, 0, 16'h0001, 1, 0, 0, 1);
    add(8'h1E, 1, 0, 16'h0012, 2, 0, 0, 1);
    add(8'h26, 1, 0, 16'h0123, 3, 0, 0, 1);
    add(8'h5A, 1, 0, 16'h0123, 3, 1, 0, 0);
    add(8'h45, 1, 0, 16'h0123, 3, 1, 0, 0);
    add(8'h00, 0, 1, 16'h0000, 0, 0, 0, 1);
    // Break code discards the following byte
    add(8'h16, 1, 0, 16'h0001, 1, 0, 0, 1);
    add(8'hF0, 1, 0, 16'h0001, 1, 0, 0, 1);
    add(8'h16, 1, 0, 16'h0001, 1, 0, 0, 1);
    add(8'h1E, 1, 0, 16'h0012, 2, 0, 0, 1);
    add(8'h5A, 1, 0, 16'h0012, 2, 1, 0, 0);
    add(8'h00, 0, 1, 16'h0000, 0, 0, 0, 1);
    // Overflow at MAX_DIGITS
    add(8'h16, 1, 0, 16'h0001, 1, 0, 0, 1);
    add(8'h1E, 1, 0, 16'h0012, 2, 0, 0, 1);
    add(8'h26, 1, 0, 16'h0123, 3, 0, 0, 1);
    add(8'h25, 1, 0, 16'h1234, 4, 0, 0, 1);
    add(8'h2E, 1, 0, 16'h1234, 4, 0, 1, 1);
    add(8'h5A, 1, 0, 16'h1234, 4, 1, 0, 0);
    add(8'h00, 0, 1, 16'h0000, 0, 0, 0, 1);
    // Empty Enter, then keypad Enter via E0
    add(8'h5A, 1, 0, 16'h0000, 0, 0, 1, 1);
    add(8'h36, 1, 0, 16'h0006, 1, 0, 0, 1);
    add(8'hE0, 1, 0, 16'h0006, 1, 0, 0, 1);
    add(8'h5A, 1, 0, 16'h0006, 1, 1, 0, 0);
    add(8'h00, 0, 1, 16'h0000, 0, 0, 0, 1);
    // Ack outside HOLD ignored, invalid byte ignored, Esc clears
    add(8'h45, 1, 1, 16'h0000, 1, 0, 0, 1);
    add(8'h16, 0, 0, 16'h0000, 1, 0, 0, 1);
    add(8'h77, 1, 0, 16'h0000, 1, 0, 0, 1);
    add(8'h76, 1, 0, 16'h0000, 0, 0, 0, 1);
    // Break swallows Enter and F0; prefix discards others
    add(8'h16, 1, 0, 16'h0001, 1, 0, 0, 1);
    add(8'hF0, 1, 0, 16'h0001, 1, 0, 0, 1);
    add(8'h5A, 1, 0, 16'h0001, 1, 0, 0, 1);
    add(8'hF0, 1, 0, 16'h0001, 1, 0, 0, 1);
    add(8'hF0, 1, 0, 16'h0001, 1, 0, 0, 1);
    add(8'h1E, 1, 0, 16'h0012, 2, 0, 0, 1);
    add(8'hE0, 1, 0, 16'h0012, 2, 0, 0, 1);
    add(8'h16, 1, 0, 16'h0012, 2, 0, 0, 1);
    add(8'hE0, 1, 0, 16'h0012, 2, 0, 0, 1);
    add(8'hF0, 1, 0, 16'h0012, 2, 0, 0, 1);
    add(8'h1E, 1, 0, 16'h0012, 2, 0, 0, 1);
    add(8'h26, 1, 0, 16'h0123, 3, 0, 0, 1);
    add(8'h76, 1, 0, 16'h0000, 0, 0, 0, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].code, tbl[i].valid, tbl[i].ack);
      check($sformatf("table[%0d]", i), tbl[i].digits, tbl[i].count, tbl[i].rv, tbl[i].err,
            tbl[i].rdy);
    end

    // Backspace key, behaviour depends on build option
    drive(8'h16, 1, 0);
    drive(8'h1E, 1, 0);
    drive(8'h66, 1, 0);
    drive(8'h26, 1, 0);
    drive(8'h5A, 1, 0);
`ifdef KEYPAD_BACKSPACE_EN
    check("backspace_commit", 16'h0013, 4'd2, 1, 0, 0);
`else
    check("backspace_commit", 16'h0123, 4'd3, 1, 0, 0);
`endif
    drive(8'h00, 0, 1);
    check("backspace_ack", 16'h0000, 4'd0, 0, 0, 1);

    // Randomized stimulus against the model
    m_reset();
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 15);
      if (r < 10)       c = SCAN[r];
      else if (r == 10) c = 8'h5A;
      else if (r == 11) c = 8'h76;
      else if (r == 12) c = 8'hF0;
      else if (r == 13) c = 8'hE0;
      else if (r == 14) c = 8'h66;
      else              c = 8'($urandom_range(0, 255));
      v = ($urandom_range(0, 3) != 0);
      a = ($urandom_range(0, 3) == 0);
      model_step(c, v, a);
      drive(c, v, a);
      check($sformatf("rand[%0d] code=%h v=%b a=%b", i, c, v, a), m_value(),
            4'(m_q.size()), m_hold, m_err, !m_hold);
    end

    // Reset while holding takes effect without a clock edge
    drive(8'h00, 0, 1);
    drive(8'h76, 1, 0);
    drive(8'h16, 1, 0);
    drive(8'h5A, 1, 0);
    check("hold_before_reset", 16'h0001, 4'd1, 1, 0, 0);
    @(negedge clk);
    code_valid = 1'b0;
    result_ack = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_in_hold", 16'h0000, 4'd0, 0, 0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    drive(8'h26, 1, 0);
    check("first_edge_after_reset", 16'h0003, 4'd1, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
